// File: rtl/elevator_car_if.sv
// elevator_car_if: request and status signals between a button panel (master)
// and the elevator car controller (slave).
interface elevator_car_if #(
  parameter int NUM_FLOORS = 9
);
  logic [4:0]            current;
  logic [4:0]            destination;
  logic                  input_confirm;
  logic [4:0]            car_floor;
  logic [NUM_FLOORS-1:0] floor_lamps;
  logic                  moving_up;
  logic                  moving_down;
  logic                  door_open;
  logic                  busy;
  logic                  arrived;
  logic                  req_err;

  modport master (
    output current, destination, input_confirm,
    input  car_floor, floor_lamps, moving_up, moving_down, door_open, busy, arrived, req_err
  );

  modport slave (
    input  current, destination, input_confirm,
    output car_floor, floor_lamps, moving_up, moving_down, door_open, busy, arrived, req_err
  );
endinterface

// File: rtl/elevator_car_controller.sv
// elevator_car_controller: serves one (pickup, destination) request at a time.
// It travels to the pickup floor and cycles the door, then travels to the
// destination floor and cycles the door again. All outputs are registered.
// Optional feature macro: REQ_HOLD_EN -- a one-entry hold register for a valid
// request that arrives while busy; it is started as soon as the current trip ends.
module elevator_car_controller #(
  parameter int NUM_FLOORS  = 9,
  parameter int FLOOR_TICKS = 50,
  parameter int DOOR_TICKS  = 20,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  elevator_car_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, GOTO_PICK, DOOR_PICK, GOTO_DEST, DOOR_DEST
  } state_t;

  localparam logic [4:0]       TOP_FLOOR  = 5'(NUM_FLOORS);
  localparam logic [CNT_W-1:0] FLOOR_LAST = CNT_W'(FLOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST  = CNT_W'(DOOR_TICKS - 1);

  state_t                state, state_d;
  logic [4:0]            car_q, car_d;
  logic [4:0]            pick_r, pick_d;
  logic [4:0]            dest_r, dest_d;
  logic [4:0]            target;
  logic [CNT_W-1:0]      timer, timer_d;
  logic                  confirm_q, rise, req_ok, accept;
  logic                  up_q, down_q, door_q, busy_q, arrived_q, req_err_q;
  logic                  up_d, down_d, door_d, busy_d, arrived_d, req_err_d;
  logic [NUM_FLOORS-1:0] lamps_q;
`ifdef REQ_HOLD_EN
  logic                  hold_v, hold_v_d;
  logic [4:0]            hold_pick, hold_pick_d;
  logic [4:0]            hold_dest, hold_dest_d;
`endif

  assign rise   = bus.input_confirm & ~confirm_q;
  assign req_ok = (bus.current != 5'd0) && (bus.current <= TOP_FLOOR) &&
                  (bus.destination != 5'd0) && (bus.destination <= TOP_FLOOR);
  assign accept = rise & req_ok;
  assign target = (state == GOTO_PICK) ? pick_r : dest_r;

  // Next-state, timer, car position and the next value of every registered output
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d   = state;
    car_d     = car_q;
    pick_d    = pick_r;
    dest_d    = dest_r;
    timer_d   = timer;
    arrived_d = 1'b0;
    req_err_d = rise & ~req_ok;
`ifdef REQ_HOLD_EN
    hold_v_d    = hold_v;
    hold_pick_d = hold_pick;
    hold_dest_d = hold_dest;
    if (accept && state != IDLE) begin
      hold_v_d    = 1'b1;
      hold_pick_d = bus.current;
      hold_dest_d = bus.destination;
    end
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          pick_d  = bus.current;
          dest_d  = bus.destination;
          timer_d = '0;
          state_d = GOTO_PICK;
        end
      end
      GOTO_PICK, GOTO_DEST: begin
        if (car_q == target) begin
          timer_d = '0;
          state_d = (state == GOTO_PICK) ? DOOR_PICK : DOOR_DEST;
        end else if (timer == FLOOR_LAST) begin
          timer_d = '0;
          car_d   = (car_q < target) ? car_q + 5'd1 : car_q - 5'd1;
        end else begin
          timer_d = timer + CNT_W'(1);
        end
      end
      DOOR_PICK, DOOR_DEST: begin
        if (timer == DOOR_LAST) begin
          timer_d = '0;
          if (state == DOOR_PICK) begin
            state_d = GOTO_DEST;
          end else begin
            arrived_d = 1'b1;
            state_d   = IDLE;
`ifdef REQ_HOLD_EN
            if (hold_v_d) begin
              pick_d   = hold_pick_d;
              dest_d   = hold_dest_d;
              hold_v_d = 1'b0;
              state_d  = GOTO_PICK;
            end
`endif
          end
        end else begin
          timer_d = timer + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Motion flags follow the position the car will hold next cycle, so they
    // drop in the same cycle the car reaches its target floor.
    up_d   = ((state_d == GOTO_PICK) && (car_d < pick_d)) ||
             ((state_d == GOTO_DEST) && (car_d < dest_d));
    down_d = ((state_d == GOTO_PICK) && (car_d > pick_d)) ||
             ((state_d == GOTO_DEST) && (car_d > dest_d));
    door_d = (state_d == DOOR_PICK) || (state_d == DOOR_DEST);
    busy_d = (state_d != IDLE);
  end

  // State, timer, request registers and registered outputs; synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      car_q     <= 5'd1;
      lamps_q   <= NUM_FLOORS'(1);
      pick_r    <= 5'd1;
      dest_r    <= 5'd1;
      timer     <= '0;
      confirm_q <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      door_q    <= 1'b0;
      busy_q    <= 1'b0;
      arrived_q <= 1'b0;
      req_err_q <= 1'b0;
`ifdef REQ_HOLD_EN
      hold_v    <= 1'b0;
      hold_pick <= 5'd1;
      hold_dest <= 5'd1;
`endif
    end else begin
      state     <= state_d;
      car_q     <= car_d;
      lamps_q   <= NUM_FLOORS'(1) << (car_d - 5'd1);
      pick_r    <= pick_d;
      dest_r    <= dest_d;
      timer     <= timer_d;
      confirm_q <= bus.input_confirm;
      up_q      <= up_d;
      down_q    <= down_d;
      door_q    <= door_d;
      busy_q    <= busy_d;
      arrived_q <= arrived_d;
      req_err_q <= req_err_d;
`ifdef REQ_HOLD_EN
      hold_v    <= hold_v_d;
      hold_pick <= hold_pick_d;
      hold_dest <= hold_dest_d;
`endif
    end
  end

  assign bus.car_floor   = car_q;
  assign bus.floor_lamps = lamps_q;
  assign bus.moving_up   = up_q;
  assign bus.moving_down = down_q;
  assign bus.door_open   = door_q;
  assign bus.busy        = busy_q;
  assign bus.arrived     = arrived_q;
  assign bus.req_err     = req_err_q;
endmodule
